pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's combinational ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in.
- The carry chain is split into STAGES registered segments, so it can be used on datapaths where a full-width ripple misses timing.
- Valid/ready handshakes on both sides, full-pipeline stall on backpressure, per-transaction mode, signed-overflow flag.

---
 rtl/pipelined_addsub.sv | 105 ++++++++++
 tb/tb_pipelined_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Segmented add/subtract with carry/borrow-in. Latency STAGES cycles from acceptance to out_valid.
// Any backpressure stalls every stage and blocks input acceptance until out_ready returns.
module pipelined_addsub #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);
   localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
   localparam int LAST = WIDTH - (STAGES - 1) * SEG;
   localparam int L    = STAGES - 1;

   if (STAGES < 1 || STAGES > WIDTH || LAST < 1) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH/STAGES leave an empty last segment");
   end

   logic                         advance;
   logic                         in_fire;
   logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
   logic [STAGES-1:0][WIDTH-1:0] op_a, op_b, op_s, nxt_s;
   logic [STAGES-1:0]            c_q, v_q;
   logic [STAGES-1:0]            op_c, op_v, nxt_c;
   logic                         ovf_q, ovf_nxt;

   assign advance  = !v_q[L] || out_ready;
   assign in_ready = advance && !rst;
   assign in_fire  = in_valid && in_ready;

   // Stage 0 works on the inverted B and carry for subtract, so sub never travels down the pipe.
   always_comb begin
      op_a[0] = a_in;
      op_b[0] = b_in ^ {WIDTH{sub}};
      op_s[0] = '0;
      op_c[0] = c_in ^ sub;
      op_v[0] = in_fire;
      for (int k = 1; k < STAGES; k++) begin
         op_a[k] = a_q[k-1];
         op_b[k] = b_q[k-1];
         op_s[k] = s_q[k-1];
         op_c[k] = c_q[k-1];
         op_v[k] = v_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      localparam int LO = k * SEG;
      localparam int WK = (k == L) ? LAST : SEG;
      localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << WK) - WIDTH'(1)) << LO;

      logic [WK:0] seg;

      assign seg      = {1'b0, op_a[k][LO+WK-1:LO]} + {1'b0, op_b[k][LO+WK-1:LO]}
                      + {{WK{1'b0}}, op_c[k]};
      assign nxt_s[k] = (op_s[k] & ~MASK) | (WIDTH'(seg[WK-1:0]) << LO);
      assign nxt_c[k] = seg[WK];
   end

   assign ovf_nxt = (op_a[L][WIDTH-1] == op_b[L][WIDTH-1])
                 && (nxt_s[L][WIDTH-1] != op_a[L][WIDTH-1]);

   // Data only loads behind a valid token, so the outputs keep the last result through bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
      end else if (advance) begin
         v_q <= op_v;
         for (int k = 0; k < STAGES; k++) begin
            if (op_v[k]) begin
               a_q[k] <= op_a[k];
               b_q[k] <= op_b[k];
               s_q[k] <= nxt_s[k];
               c_q[k] <= nxt_c[k];
            end
         end
         if (op_v[L]) begin
            ovf_q <= ovf_nxt;
         end
      end
   end

   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign carry     = c_q[L];
   assign overflow  = ovf_q;

   logic unused_ops;
   assign unused_ops = ^{a_q[L], b_q[L]};
endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
// Scoreboard bench for pipelined_addsub in three geometries driven with the same accepted stream.
module tb_pipelined_addsub;
   typedef struct packed {
      logic [23:0] s;
      logic        c;
      logic        o;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        drv_valid, out_ready;
   logic [23:0] drv_a, drv_b;
   logic        drv_c, drv_sub;
   logic        in_vld, all_ready;

   logic        rdy24, v24, c24, o24;
   logic [23:0] s24;
   logic        rdy1, v1, c1, o1;
   logic [23:0] s1;
   logic        rdy7, v7, c7, o7;
   logic [6:0]  s7;

   int   total = 0;
   int   bad = 0;
   int   stall_left = 0;
   int   pushed[3];
   int   recv[3];
   res_t q0[$];
   res_t q1[$];
   res_t q2[$];
   bit          held[3];
   logic [23:0] held_s[3];
   logic        held_c[3];
   logic        held_o[3];

   initial forever #5 clk = ~clk;

   assign all_ready = rdy24 && rdy1 && rdy7;
   assign in_vld    = drv_valid && all_ready;

   pipelined_addsub #(.WIDTH(24), .STAGES(3)) u24 (
      .clk(clk), .rst(rst_a), .in_valid(in_vld), .in_ready(rdy24),
      .a_in(drv_a), .b_in(drv_b), .c_in(drv_c), .sub(drv_sub),
      .out_valid(v24), .out_ready(out_ready), .sum(s24), .carry(c24), .overflow(o24));

   pipelined_addsub #(.WIDTH(24), .STAGES(1)) u1 (
      .clk(clk), .rst(rst_b), .in_valid(in_vld), .in_ready(rdy1),
      .a_in(drv_a), .b_in(drv_b), .c_in(drv_c), .sub(drv_sub),
      .out_valid(v1), .out_ready(out_ready), .sum(s1), .carry(c1), .overflow(o1));

   pipelined_addsub #(.WIDTH(7), .STAGES(4)) u7 (
      .clk(clk), .rst(rst_b), .in_valid(in_vld), .in_ready(rdy7),
      .a_in(drv_a[6:0]), .b_in(drv_b[6:0]), .c_in(drv_c), .sub(drv_sub),
      .out_valid(v7), .out_ready(out_ready), .sum(s7), .carry(c7), .overflow(o7));

   // Reference: plain integer arithmetic, overflow judged on the true signed result.
   function automatic res_t model(input int w, input logic [23:0] a, input logic [23:0] b,
                                  input logic ci, input logic sb);
      res_t r;
      int mask, half, ua, ub, cin, full, sa, sbv, sr;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      ua   = {8'd0, a};
      ub   = {8'd0, b};
      ua   = ua & mask;
      ub   = ub & mask;
      cin  = {31'd0, ci};
      full = sb ? (ua - ub - cin) : (ua + ub + cin);
      r.s  = 24'(full & mask);
      r.c  = sb ? (full >= 0) : (((full >> w) & 1) == 1);
      sa   = (ua >= half) ? ua - (1 << w) : ua;
      sbv  = (ub >= half) ? ub - (1 << w) : ub;
      sr   = sb ? (sa - sbv - cin) : (sa + sbv + cin);
      r.o  = (sr >= half) || (sr < -half);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = 1'b1;
      end
      #1;
   endtask

   task automatic send(input logic [23:0] a, input logic [23:0] b, input logic ci,
                       input logic sb, input bit hand, input logic [23:0] hs,
                       input logic hc, input logic ho);
      int   guard;
      res_t e;
      guard     = 0;
      drv_a     = a;
      drv_b     = b;
      drv_c     = ci;
      drv_sub   = sb;
      drv_valid = 1'b1;
      while (!all_ready && guard < 50) begin
         if (!out_ready && v24) chk("stall_in_ready", 32'(rdy24), 32'd0);
         tick();
         guard++;
      end
      if (!all_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout got in_ready=%b%b%b want 111", rdy24, rdy1, rdy7);
         drv_valid = 1'b0;
         return;
      end
      e = hand ? {hs, hc, ho} : model(24, a, b, ci, sb);
      q0.push_back(e);
      q1.push_back(model(24, a, b, ci, sb));
      q2.push_back(model(7, a, b, ci, sb));
      pushed[0]++;
      pushed[1]++;
      pushed[2]++;
      tick();
      drv_valid = 1'b0;
   endtask

   task automatic qpop(input int id, output res_t e, output bit ok);
      ok = 1'b1;
      e  = '0;
      case (id)
         0: if (q0.size() != 0) e = q0.pop_front(); else ok = 1'b0;
         1: if (q1.size() != 0) e = q1.pop_front(); else ok = 1'b0;
         default: if (q2.size() != 0) e = q2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   task automatic mon_check(input int id, input logic vld, input logic rdy,
                            input logic [23:0] s, input logic c, input logic o);
      res_t e;
      bit   ok;
      if (held[id]) begin
         total++;
         if (vld !== 1'b1 || s !== held_s[id] || c !== held_c[id] || o !== held_o[id]) begin
            bad++;
            $display("FAIL hold_stable dut%0d got vld=%b sum=%h c=%b o=%b want vld=1 sum=%h c=%b o=%b",
                     id, vld, s, c, o, held_s[id], held_c[id], held_o[id]);
         end
      end
      held[id]   = vld && !rdy;
      held_s[id] = s;
      held_c[id] = c;
      held_o[id] = o;
      if (vld && rdy) begin
         qpop(id, e, ok);
         total++;
         recv[id]++;
         if (!ok) begin
            bad++;
            $display("FAIL unexpected_out dut%0d got sum=%h c=%b o=%b want no result", id, s, c, o);
         end else if ({s, c, o} !== {e.s, e.c, e.o}) begin
            bad++;
            $display("FAIL result dut%0d got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     id, s, c, o, e.s, e.c, e.o);
         end
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      mon_check(0, v24, out_ready, s24, c24, o24);
      mon_check(1, v1, out_ready, s1, c1, o1);
      mon_check(2, v7, out_ready, {17'd0, s7}, c7, o7);
   end

   task automatic drain();
      for (int i = 0; i < 60 && (q0.size() + q1.size() + q2.size()) != 0; i++) tick();
      tick();
      chk("drain_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         pushed[i] = 0;
         recv[i]   = 0;
         held[i]   = 1'b0;
      end
      rst_a = 1'b1; rst_b = 1'b1;
      drv_valid = 1'b0; out_ready = 1'b1;
      drv_a = '0; drv_b = '0; drv_c = 1'b0; drv_sub = 1'b0;

      // Reset held for two edges
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_valid", {29'd0, v24, v1, v7}, 32'd0);
         chk("rst_sum", 32'(s24), 32'd0);
         chk("rst_in_ready", {29'd0, rdy24, rdy1, rdy7}, 32'd0);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      chk("post_rst_in_ready", {29'd0, rdy24, rdy1, rdy7}, 32'h7);

      // Full carry ripple, and first-result latency of each geometry
      send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("lat_s3", 32'(v24), 32'(i == 2));
         chk("lat_s1", 32'(v1), 32'(i == 0));
         chk("lat_w7", 32'(v7), 32'(i == 3));
         tick();
      end

      // Directed corners with hand-computed 24-bit results
      send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 1'b1, 24'h800000, 1'b0, 1'b1);
      send(24'h000000, 24'h000001, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
      send(24'h800000, 24'h000001, 1'b0, 1'b1, 1'b1, 24'h7FFFFF, 1'b1, 1'b1);
      send(24'h123456, 24'h654321, 1'b1, 1'b0, 1'b1, 24'h777778, 1'b0, 1'b0);
      send(24'h000005, 24'h000003, 1'b1, 1'b1, 1'b1, 24'h000001, 1'b1, 1'b0);
      send(24'h000010, 24'h000010, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0);
      drain();

      // Back-to-back stream: one result per cycle once the pipe is full
      for (int i = 0; i < 20; i++) begin
         send(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, 24'd0, 1'b0, 1'b0);
         if (i >= 2) chk("stream_out_valid", 32'(v24), 32'd1);
      end
      drain();

      // Backpressure: out_ready low for 4 cycles after 3 of 6 transactions
      for (int i = 0; i < 6; i++) begin
         send(24'h0F0F00 + 24'(i * 24'h031337), 24'h00A5A5 + 24'(i * 24'h10001),
              1'(i & 1), 1'((i >> 1) & 1), 1'b0, 24'd0, 1'b0, 1'b0);
         if (i == 2) begin
            out_ready  = 1'b0;
            stall_left = 3;
            #1;
            chk("bp_out_valid", 32'(v24), 32'd1);
            chk("bp_in_ready", 32'(rdy24), 32'd0);
         end
      end
      drain();

      // Reset mid-flight on the 3-stage unit: both accepted transactions must vanish
      send(24'h111111, 24'h222222, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
      send(24'h333333, 24'h000001, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
      chk("midrst_not_yet", 32'(v24), 32'd0);
      rst_a = 1'b1;
      pushed[0] -= q0.size();
      q0.delete();
      #1;
      tick();
      chk("midrst_valid", 32'(v24), 32'd0);
      chk("midrst_sum", 32'(s24), 32'd0);
      rst_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_quiet", 32'(v24), 32'd0);
      end
      send(24'h000005, 24'h000003, 1'b1, 1'b1, 1'b1, 24'h000001, 1'b1, 1'b0);
      drain();

      for (int i = 0; i < 3; i++) chk("recv_count", 32'(recv[i]), 32'(pushed[i]));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
